// File: rtl/fft_frame_capture_buffer_if.sv
// Sample stream and readback bus of the FFT frame capture buffer.
// The master side produces samples and read requests; the slave side is the buffer.
interface fft_frame_capture_buffer_if #(
   parameter int DATA_WIDTH = 21,
   parameter int ADDR_WIDTH = 13
);
   logic                  valid;
   logic                  sop;
   logic                  eop;
   logic [DATA_WIDTH-1:0] data;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   modport master (
      output valid, sop, eop, data, rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  valid, sop, eop, data, rd_en, rd_addr,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/fft_frame_capture_buffer.sv
// Captures sop/eop-delimited FFT magnitude frames into RAM (single-shot or ring),
// tracks the capture peak, and offers a 1-cycle readback port.
module fft_frame_capture_buffer #(
   parameter int DATA_WIDTH = 21,
   parameter int ADDR_WIDTH = 13,
   parameter int FRAMES_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  mode,
   input  logic [FRAMES_W-1:0]   num_frames,
   fft_frame_capture_buffer_if.slave bus,
   output logic [1:0]            state,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   write_count,
   output logic [FRAMES_W-1:0]   frame_count,
   output logic [DATA_WIDTH-1:0] peak_value,
   output logic [ADDR_WIDTH-1:0] peak_addr,
   output logic                  overflow,
   output logic                  frame_err
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ARMED   = 2'b01,
      S_CAPTURE = 2'b10,
      S_DONE    = 2'b11
   } state_t;

   typedef struct packed {
      logic                  en;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wr_req_t;

   state_t                st;
   logic                  cont;
   logic [FRAMES_W-1:0]   target;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic                  in_frame;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   wr_req_t               wr;
   logic                  start;
   logic                  full;
   logic                  drop;
   logic                  last_frame;
   logic [FRAMES_W-1:0]   fc_inc;

   // abort suppresses any write in its cycle; a full single-shot buffer drops the sample
   always_comb begin
      start      = bus.valid && bus.sop && (st == S_ARMED) && !abort;
      full       = !cont && (write_count == FULL);
      drop       = bus.valid && (st == S_CAPTURE) && full && !abort;
      wr.en      = start || (bus.valid && (st == S_CAPTURE) && !full && !abort);
      wr.addr    = wr_ptr;
      wr.data    = bus.data;
      fc_inc     = frame_count + FRAMES_W'(1);
      last_frame = !cont && bus.eop && (fc_inc == target);
   end

   always_ff @(posedge clk)
      if (wr.en) mem[wr.addr] <= wr.data;

   // Nonblocking read of the array gives read-before-write on a same-address collision
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
      end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         st          <= S_IDLE;
         cont        <= 1'b0;
         target      <= '0;
         wr_ptr      <= '0;
         in_frame    <= 1'b0;
         write_count <= '0;
         frame_count <= '0;
         peak_value  <= '0;
         peak_addr   <= '0;
         overflow    <= 1'b0;
         frame_err   <= 1'b0;
      end else if (abort) begin
         st <= S_IDLE;
      end else begin
         case (st)
            S_IDLE, S_DONE:
               if (arm) begin
                  st          <= S_ARMED;
                  cont        <= mode;
                  target      <= (num_frames == '0) ? FRAMES_W'(1) : num_frames;
                  wr_ptr      <= '0;
                  in_frame    <= 1'b0;
                  write_count <= '0;
                  frame_count <= '0;
                  peak_value  <= '0;
                  peak_addr   <= '0;
                  overflow    <= 1'b0;
                  frame_err   <= 1'b0;
               end
            S_ARMED:
               if (start) st <= last_frame ? S_DONE : S_CAPTURE;
            S_CAPTURE:
               if (drop) begin
                  overflow <= 1'b1;
                  st       <= S_DONE;
               end else if (wr.en && last_frame) begin
                  st <= S_DONE;
               end
            default: st <= S_IDLE;
         endcase

         if (wr.en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (write_count != FULL) write_count <= write_count + 1'b1;
            // the first write of a capture always seeds the peak; ties keep the earlier address
            if ((st == S_ARMED) || (bus.data > peak_value)) begin
               peak_value <= bus.data;
               peak_addr  <= wr_ptr;
            end
            if (bus.eop) frame_count <= fc_inc;
            if ((st == S_CAPTURE) && bus.sop && in_frame) frame_err <= 1'b1;
            if (bus.eop)      in_frame <= 1'b0;
            else if (bus.sop) in_frame <= 1'b1;
         end
      end

   assign state = st;
   assign busy  = (st == S_ARMED) || (st == S_CAPTURE);
   assign done  = (st == S_DONE);
endmodule

// File: tb/tb_fft_frame_capture_buffer.sv
// Bench for fft_frame_capture_buffer: table of capture scenarios with final-status
// expectations, readback checked through a queue scoreboard, plus corner sequences.
module tb_fft_frame_capture_buffer;
   localparam int DW = 21;
   localparam int AW = 4;
   localparam int FW = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          arm, abort, mode;
   logic [FW-1:0] num_frames;
   logic [1:0]    state;
   logic          busy, done, overflow, frame_err;
   logic [AW:0]   write_count;
   logic [FW-1:0] frame_count;
   logic [DW-1:0] peak_value;
   logic [AW-1:0] peak_addr;

   fft_frame_capture_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fft_frame_capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAMES_W(FW)) dut (
      .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .mode(mode),
      .num_frames(num_frames), .bus(bus), .state(state), .busy(busy), .done(done),
      .write_count(write_count), .frame_count(frame_count), .peak_value(peak_value),
      .peak_addr(peak_addr), .overflow(overflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mode, nf, pre, len, flen, xsop, dk;
      int e_state, e_wc, e_fc, e_peak, e_paddr, e_ovf, e_ferr;
   } scn_t;

   scn_t          tbl [7];
   int            n_cmp = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_mem [DEPTH];
   bit            known [DEPTH];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (reset_n && bus.rd_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_unexpected: got rd_valid with data %0d, expected no read", bus.rd_data);
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", bus.rd_data, e);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      bus.valid = 0; bus.sop = 0; bus.eop = 0; bus.data = '0;
      bus.rd_en = 0; bus.rd_addr = '0;
      arm = 0; abort = 0;
   endtask

   function automatic int dval(input int dk, input int i);
      case (dk)
         0:       return i * 3;
         1:       return i * 3 + 1;
         2:       return i + 1;
         3:       return 10 + i;
         4:       return (i == 2 || i == 6) ? 100 : i;
         5:       return 7;
         default: return 50 - i;
      endcase
   endfunction

   task automatic readback;
      for (int a = 0; a < DEPTH; a++) begin
         if (known[a]) begin
            bus.rd_en = 1; bus.rd_addr = AW'(a);
            exp_q.push_back(exp_mem[a]);
            tick;
         end
      end
      bus.rd_en = 0;
      tick; tick;
      chk("rd_drain", exp_q.size(), 0);
   endtask

   task automatic run_scn(input scn_t s);
      int ptr, cnt, fr, tgt, d;
      bit stop, so, eo;
      ptr = 0; cnt = 0; fr = 0; stop = 0;
      tgt = (s.nf == 0) ? 1 : s.nf;
      mode = s.mode[0]; num_frames = FW'(s.nf); arm = 1;
      tick;
      arm = 0;
      chk("arm_state", state, 1);
      chk("arm_busy", busy, 1);
      chk("arm_wc", write_count, 0);
      chk("arm_fc", frame_count, 0);
      chk("arm_peak", peak_value, 0);
      chk("arm_flags", {overflow, frame_err}, 0);
      for (int i = 0; i < s.pre; i++) begin
         bus.valid = 1; bus.sop = 0; bus.eop = 0; bus.data = DW'(1000 + i);
         tick;
      end
      for (int i = 0; i < s.len; i++) begin
         d  = dval(s.dk, i);
         so = (s.flen == 0) ? (i == 0) : (i % s.flen == 0);
         so = so | (i == s.xsop);
         eo = (s.flen != 0) && (i % s.flen == s.flen - 1);
         bus.valid = 1; bus.sop = so; bus.eop = eo; bus.data = DW'(d);
         if (!stop) begin
            if (s.mode == 0 && cnt == DEPTH) stop = 1;
            else begin
               exp_mem[ptr] = DW'(d); known[ptr] = 1;
               ptr = (ptr + 1) % DEPTH; cnt++;
               if (eo) begin
                  fr++;
                  if (s.mode == 0 && fr == tgt) stop = 1;
               end
            end
         end
         tick;
      end
      idle_in;
      tick;
      chk("state", state, s.e_state);
      chk("busy", busy, (s.e_state == 1 || s.e_state == 2));
      chk("done", done, (s.e_state == 3));
      chk("write_count", write_count, s.e_wc);
      chk("frame_count", frame_count, s.e_fc);
      chk("peak_value", peak_value, s.e_peak);
      chk("peak_addr", peak_addr, s.e_paddr);
      chk("overflow", overflow, s.e_ovf);
      chk("frame_err", frame_err, s.e_ferr);
      readback();
   endtask

   initial begin
      //           mode nf pre len flen xsop dk  st  wc fc peak paddr ovf ferr
      tbl[0] = '{0, 1, 0, 16, 16, -1, 0,  3, 16, 1, 45,  15, 0, 0};
      tbl[1] = '{0, 1, 3,  8,  8, -1, 1,  3,  8, 1, 22,   7, 0, 0};
      tbl[2] = '{0, 2, 0, 20,  0, -1, 2,  3, 16, 0, 16,  15, 1, 0};
      tbl[3] = '{1, 0, 0, 24,  8, -1, 3,  2, 16, 3, 33,   7, 0, 0};
      tbl[4] = '{0, 1, 0, 10, 10,  4, 4,  3, 10, 1, 100,  2, 0, 1};
      tbl[5] = '{0, 0, 0,  1,  1, -1, 5,  3,  1, 1,  7,   0, 0, 0};
      tbl[6] = '{0, 2, 0, 16,  8, -1, 6,  3, 16, 2, 50,   0, 0, 0};
      for (int a = 0; a < DEPTH; a++) known[a] = 0;
      idle_in; mode = 0; num_frames = '0;
      tick; tick;
      chk("rst_state", state, 0);
      chk("rst_status", {busy, done, overflow, frame_err, bus.rd_valid}, 0);
      chk("rst_counts", {write_count, frame_count}, 0);
      chk("rst_peak", {peak_value, peak_addr}, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      @(negedge clk); reset_n = 1;
      tick;

      for (int k = 0; k < 7; k++) begin
         run_scn(tbl[k]);
         if (tbl[k].mode == 1) begin
            abort = 1; tick; abort = 0;
            chk("abort_state", state, 0);
            chk("abort_wc_hold", write_count, 16);
            chk("abort_fc_hold", frame_count, 3);
            chk("abort_peak_hold", peak_value, 33);
         end
      end

      // DONE ignores further samples
      bus.valid = 1; bus.sop = 1; bus.data = DW'(999);
      tick; tick;
      idle_in;
      chk("done_hold_wc", write_count, 16);
      chk("done_hold_state", state, 3);
      chk("done_hold_peak", peak_value, 50);

      // same-cycle read/write at addr 0, arm ignored mid-capture, abort beats valid and arm
      mode = 0; num_frames = FW'(1); arm = 1; tick; arm = 0;
      bus.valid = 1; bus.sop = 1; bus.data = DW'(777);
      bus.rd_en = 1; bus.rd_addr = '0;
      exp_q.push_back(exp_mem[0]);
      tick;
      exp_mem[0] = DW'(777);
      bus.rd_en = 0; bus.sop = 0; bus.data = DW'(778);
      chk("rbw_state", state, 2);
      chk("rbw_wc", write_count, 1);
      arm = 1; mode = 1;
      tick;
      exp_mem[1] = DW'(778);
      chk("arm_ignored_wc", write_count, 2);
      chk("arm_ignored_state", state, 2);
      abort = 1; bus.data = DW'(999);
      tick;
      idle_in;
      chk("abort_pri_state", state, 0);
      chk("abort_pri_wc", write_count, 2);
      chk("abort_pri_peak", peak_value, 778);
      chk("abort_pri_paddr", peak_addr, 1);
      readback();

      // asynchronous reset in the middle of a capture
      mode = 0; num_frames = FW'(1); arm = 1; tick; arm = 0;
      bus.valid = 1; bus.sop = 1; bus.data = DW'(5); tick;
      bus.sop = 0; bus.data = DW'(6); tick;
      idle_in;
      exp_mem[0] = DW'(5); exp_mem[1] = DW'(6);
      chk("pre_rst_state", state, 2);
      #2 reset_n = 0;
      #1;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_status", {busy, done, overflow, frame_err, bus.rd_valid}, 0);
      chk("mid_rst_counts", {write_count, frame_count}, 0);
      chk("mid_rst_peak", {peak_value, peak_addr}, 0);
      @(negedge clk); reset_n = 1;
      tick;
      run_scn(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
